rgb_relation_decoder: RTL and testbench

Receive-side decoder for the 2-bit magnitude comparator's three-line indicator output (R, G, B). It synchronizes the indicator lines, filters glitches, and turns each newly stable indicator code into a relation code (LT/EQ/GT) or an error. Results are delivered on a valid/ready interface, and per-relation event counters are kept. The block sits between the comparator's indicator outputs and any sequential consumer, such as a scoreboard, a display controller, or a self-test sequencer.

---
 rtl/rgb_relation_decoder_if.sv | 10 +
 rtl/rgb_relation_decoder.sv | 152 +++++++++++++++
 tb/tb_rgb_relation_decoder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rgb_relation_decoder_if.sv
// Result handshake between the RGB relation decoder and its consumer.
// The decoder drives valid/code; the consumer drives ready.
interface rgb_relation_decoder_if;
    logic       rel_valid;
    logic       rel_ready;
    logic [1:0] rel_code;

    modport master (output rel_valid, output rel_code, input rel_ready);
    modport slave  (input rel_valid, input rel_code, output rel_ready);
endinterface

// File: rtl/rgb_relation_decoder.sv
// Synchronizes and debounces the comparator's R/G/B indicator lines, turns each
// newly stable code into a relation result, and counts results per relation.
module rgb_relation_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   r_in,
    input  logic                   g_in,
    input  logic                   b_in,
    input  logic                   clr_cnt,
    rgb_relation_decoder_if.master rel,
    output logic                   overrun,
    output logic [CNT_W-1:0]       lt_count,
    output logic [CNT_W-1:0]       eq_count,
    output logic [CNT_W-1:0]       gt_count,
    output logic [CNT_W-1:0]       err_count
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] STAB_PRE = 4'(STABLE_CYCLES - 1);
    localparam logic [1:0] REL_LT  = 2'b00;
    localparam logic [1:0] REL_EQ  = 2'b01;
    localparam logic [1:0] REL_GT  = 2'b10;
    localparam logic [1:0] REL_ERR = 2'b11;

    logic [2:0]       sync1_q, sync2_q, cand_q, last_acc_q;
    logic             last_vld_q;
    logic [3:0]       stab_cnt_q;
    logic             acc_q;
    logic [1:0]       acc_code_q;
    state_e           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic             ovr_set;
    logic             accept;
    logic [1:0]       cand_rel;
    logic             overrun_q;
    logic [CNT_W-1:0] lt_q, eq_q, gt_q, err_q;

    function automatic logic [1:0] decode(input logic [2:0] rgb);
        case (rgb)
            3'b110:  return REL_LT;
            3'b101:  return REL_EQ;
            3'b011:  return REL_GT;
            default: return REL_ERR;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Accept only on the exact step into STABLE_CYCLES, and only for a code
    // different from the last accepted one (last_vld_q=0 is the "none" marker).
    always_comb begin
        accept   = (sync2_q == cand_q) && (stab_cnt_q == STAB_PRE) &&
                   (!last_vld_q || (last_acc_q != cand_q));
        cand_rel = decode(cand_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            cand_q     <= 3'b000;
            stab_cnt_q <= 4'd0;
            last_acc_q <= 3'b000;
            last_vld_q <= 1'b0;
            acc_q      <= 1'b0;
            acc_code_q <= REL_LT;
        end else begin
            sync1_q <= {r_in, g_in, b_in};
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q     <= sync2_q;
                stab_cnt_q <= 4'd1;
            end else if (stab_cnt_q != STAB_MAX) begin
                stab_cnt_q <= stab_cnt_q + 4'd1;
            end
            acc_q      <= accept;
            acc_code_q <= cand_rel;
            if (accept) begin
                last_acc_q <= cand_q;
                last_vld_q <= 1'b1;
            end
        end
    end

    // A full slot with ready and a fresh acceptance reloads without a bubble.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ovr_set = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc_q) begin
                    state_d = FULL;
                    code_d  = acc_code_q;
                end
            end
            FULL: begin
                if (acc_q) begin
                    if (rel.rel_ready) code_d = acc_code_q;
                    else               ovr_set = 1'b1;
                end else if (rel.rel_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            code_q  <= REL_LT;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            overrun_q <= 1'b0;
            lt_q      <= '0;
            eq_q      <= '0;
            gt_q      <= '0;
            err_q     <= '0;
        end else begin
            if (ovr_set) overrun_q <= 1'b1;
            if (acc_q) begin
                case (acc_code_q)
                    REL_LT:  lt_q  <= sat_inc(lt_q);
                    REL_EQ:  eq_q  <= sat_inc(eq_q);
                    REL_GT:  gt_q  <= sat_inc(gt_q);
                    default: err_q <= sat_inc(err_q);
                endcase
            end
        end
    end

    assign rel.rel_valid = (state_q == FULL);
    assign rel.rel_code  = code_q;
    assign overrun       = overrun_q;
    assign lt_count      = lt_q;
    assign eq_count      = eq_q;
    assign gt_count      = gt_q;
    assign err_count     = err_q;
endmodule

// File: tb/tb_rgb_relation_decoder.sv
// Directed bench for rgb_relation_decoder; transfers are scoreboarded against
// a queue of expected codes, status/counters are checked inline.
module tb_rgb_relation_decoder;
    logic clk = 1'b0;
    logic rst_n, r_in, g_in, b_in, clr_cnt;
    logic       ovr, ovr2;
    logic [7:0] lt, eq, gt, err;
    logic [1:0] lt2, eq2, gt2, err2;

    int total = 0;
    int bad = 0;
    int vcyc = 0;
    logic [1:0] exp_q[$];

    rgb_relation_decoder_if rif ();
    rgb_relation_decoder_if rif2 ();
    assign rif2.rel_ready = 1'b1;

    rgb_relation_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .clr_cnt(clr_cnt), .rel(rif), .overrun(ovr),
        .lt_count(lt), .eq_count(eq), .gt_count(gt), .err_count(err));

    rgb_relation_decoder #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .clr_cnt(clr_cnt), .rel(rif2), .overrun(ovr2),
        .lt_count(lt2), .eq_count(eq2), .gt_count(gt2), .err_count(err2));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts at a negedge, holds the pins n cycles, counts valid-high cycles.
    task automatic hold(input logic [2:0] v, input int n);
        {r_in, g_in, b_in} = v;
        for (int i = 0; i < n; i++) begin
            #1;
            if (rif.rel_valid) vcyc++;
            @(negedge clk);
        end
    endtask

    task automatic drain_one();
        rif.rel_ready = 1'b1;
        @(negedge clk);
        rif.rel_ready = 1'b0;
        #1;
        check("valid_after_drain", rif.rel_valid, 0);
        @(negedge clk);
    endtask

    // Monitor: samples between edges; a transfer happens on the next posedge.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && rif.rel_valid && rif.rel_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", int'(rif.rel_code), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("transfer_code", int'(rif.rel_code), int'(e));
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; clr_cnt = 1'b0; rif.rel_ready = 1'b0;
        {r_in, g_in, b_in} = 3'b101;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", rif.rel_valid, 0);
        check("rst_code", int'(rif.rel_code), 0);
        check("rst_overrun", ovr, 0);
        check("rst_counts", int'(lt) + int'(eq) + int'(gt) + int'(err), 0);
        @(negedge clk);

        // Latency from first edge seeing 101 to rel_valid: STABLE_CYCLES+3 edges.
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (rif.rel_valid) break;
        end
        check("latency_edges", n, 7);
        check("first_code", int'(rif.rel_code), 1);
        check("first_eq", int'(eq), 1);
        @(negedge clk);
        hold(3'b101, 20);
        check("stable_valid_held", rif.rel_valid, 1);
        check("stable_eq_once", int'(eq), 1);
        check("stable_no_overrun", ovr, 0);
        exp_q.push_back(2'b01);
        drain_one();

        // Back-to-back relations with ready tied high.
        rif.rel_ready = 1'b1;
        exp_q.push_back(2'b00); exp_q.push_back(2'b10); exp_q.push_back(2'b01);
        vcyc = 0;
        hold(3'b110, 10); hold(3'b011, 10); hold(3'b101, 10);
        check("seq_valid_cycles", vcyc, 3);
        check("seq_lt", int'(lt), 1);
        check("seq_gt", int'(gt), 1);
        check("seq_eq", int'(eq), 2);

        // 3-cycle glitch must be filtered.
        exp_q.push_back(2'b00);
        hold(3'b110, 10);
        vcyc = 0;
        hold(3'b011, 3); hold(3'b110, 10);
        check("glitch_no_result", vcyc, 0);
        check("glitch_gt", int'(gt), 1);
        check("glitch_lt", int'(lt), 2);

        // Overrun: second result dropped while first is pending.
        exp_q.push_back(2'b01);
        hold(3'b101, 10);
        rif.rel_ready = 1'b0;
        hold(3'b110, 10); hold(3'b011, 10);
        check("ovr_code_kept", int'(rif.rel_code), 0);
        check("ovr_valid", rif.rel_valid, 1);
        check("ovr_flag", ovr, 1);
        check("ovr_gt", int'(gt), 2);
        exp_q.push_back(2'b00);
        drain_one();

        // Illegal codes.
        rif.rel_ready = 1'b1;
        exp_q.push_back(2'b11); exp_q.push_back(2'b11);
        hold(3'b111, 10); hold(3'b000, 10);
        check("err_count", int'(err), 2);

        // clr_cnt lands on the same edge as a dropped acceptance.
        rif.rel_ready = 1'b0;
        hold(3'b110, 10);
        check("pre_clr_lt", int'(lt), 4);
        {r_in, g_in, b_in} = 3'b101;
        repeat (6) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        check("clr_counts", int'(lt) + int'(eq) + int'(gt) + int'(err), 0);
        check("clr_overrun", ovr, 0);
        check("clr_code_kept", int'(rif.rel_code), 0);
        @(negedge clk);
        exp_q.push_back(2'b00);
        drain_one();

        // Saturation on the 2-bit instance.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rif.rel_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(2'b00); exp_q.push_back(2'b01);
            hold(3'b110, 10); hold(3'b101, 10);
        end
        check("sat_lt2", int'(lt2), 3);
        check("sat_eq2", int'(eq2), 3);
        check("nosat_lt", int'(lt), 5);
        check("nosat_eq", int'(eq), 5);

        // Reset while a result is pending.
        rif.rel_ready = 1'b0;
        hold(3'b110, 10);
        check("pend_valid", rif.rel_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_valid", rif.rel_valid, 0);
        check("midrst_code", int'(rif.rel_code), 0);
        check("midrst_counts", int'(lt) + int'(eq) + int'(gt) + int'(err), 0);
        check("midrst_counts2", int'(lt2) + int'(eq2), 0);
        rst_n = 1'b1;
        @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
